// File: rtl/alu_shared_mult_seq.sv
// Iterative shift-add multiplier that borrows the execute-stage ALU adder.
// Signed products are formed from magnitudes and negated in a final FIX step.
module alu_shared_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   accHi;
  logic [WIDTH-1:0]   accLo;
  logic [CNT_W-1:0]   count;
  logic               neg;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic               carry;
  logic [2*WIDTH-1:0] negProd;

  always_comb begin
    absA    = (sgn && src_a[WIDTH-1]) ? ('0 - src_a) : src_a;
    absB    = (sgn && src_b[WIDTH-1]) ? ('0 - src_b) : src_b;
    alu_a   = (state == RUN) ? accHi : '0;
    alu_b   = (state == RUN && accLo[0]) ? mcand : '0;
    // The ALU returns only WIDTH bits; rebuild the carry-out from operand and sum MSBs.
    carry   = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
              ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_y[WIDTH-1]);
    negProd = '0 - {accHi, accLo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      accHi <= '0;
      accLo <= '0;
      count <= '0;
      neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= absB;
            accHi <= '0;
            accLo <= absA;
            count <= '0;
            neg   <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            state <= RUN;
          end
        end
        RUN: begin
          accHi <= {carry, alu_y[WIDTH-1:1]};
          accLo <= {alu_y[0], accLo[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (neg) {accHi, accLo} <= negProd;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);
  assign hi   = accHi;
  assign lo   = accLo;

endmodule

// File: tb/tb_alu_shared_mult_seq.sv
// Bench for alu_shared_mult_seq: vector table plus scoreboard, with handshake,
// async reset and idle corner-case sequences. Provides the borrowed ALU adder.
module tb_alu_shared_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] alu_y;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] sbQ[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  alu_shared_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn),
    .src_a(src_a), .src_b(src_b), .alu_y(alu_y),
    .alu_a(alu_a), .alu_b(alu_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  assign alu_y = alu_a + alu_b;

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one start; optionally re-pulse start with junk operands at cycles 5, 20 and on done.
  task automatic runMul(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input bit intrude);
    int cyc;
    int busyCyc;
    logic [63:0] exp;
    @(negedge clk);
    src_a = a; src_b = b; sgn = s; start = 1'b1;
    sbQ.push_back(model(a, b, s));
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busyCyc = 0;
    while (!done && cyc < 100) begin
      if (busy) busyCyc++;
      if (intrude && (cyc == 5 || cyc == 20)) begin
        start = 1'b1; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D; sgn = ~s;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({name, " latency"}, 64'(cyc), 64'd33);
    check({name, " busy cycles"}, 64'(busyCyc), 64'd33);
    if (!done) begin
      $display("FAIL %s: done never seen within 100 cycles", name);
      failures++; checks++;
      return;
    end
    check({name, " alu idle in DONE"}, {alu_a, alu_b}, 64'd0);
    if (sbQ.size() == 0) begin
      $display("FAIL %s: done with empty scoreboard", name);
      failures++; checks++;
      return;
    end
    exp = sbQ.pop_front();
    check({name, " product"}, {hi, lo}, exp);
    if (intrude) begin
      start = 1'b1; src_a = 32'h1357_9BDF; src_b = 32'h2468_ACE0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " done one cycle"}, 64'(done), 64'd0);
    check({name, " not restarted"}, 64'(busy), 64'd0);
    check({name, " product held"}, {hi, lo}, exp);
  endtask

  initial begin
    vecs[0] = '{32'd7,         32'd6,         1'b0, 64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'hFFFF_FFFD, 32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000};
    vecs[5] = '{32'd0,         32'h1234_5678, 1'b1, 64'h0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    vecs[7] = '{32'd5,         32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
    for (int i = 8; i < 12; i++) begin
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].s   = i[0];
      vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].s);
    end

    #12;
    check("reset busy/done", {62'd0, busy, done}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    check("reset alu ops", {alu_a, alu_b}, 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d table model", i), model(vecs[i].a, vecs[i].b, vecs[i].s), vecs[i].exp);
      runMul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 1'b0);
    end

    runMul("ignore start", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
    runMul("after ignore", 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0);

    @(negedge clk);
    src_a = 32'h1111_1111; src_b = 32'h0000_0003; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst busy/done", {62'd0, busy, done}, 64'd0);
    check("async rst hi/lo", {hi, lo}, 64'd0);
    check("async rst alu ops", {alu_a, alu_b}, 64'd0);
    @(negedge clk); rst = 1'b0;
    runMul("post reset 3x4", 32'd3, 32'd4, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("idle alu ops", {alu_a, alu_b}, 64'd0);
      check("idle busy/done", {62'd0, busy, done}, 64'd0);
      check("idle hold", {hi, lo}, 64'h0000_0000_0000_000C);
    end

    check("scoreboard drained", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_shared_mult_seq.md
Name: alu_shared_mult_seq

Overview:
- Iterative shift-add multiplier sequencer for the execute stage. It is the responder side of the multiply start/done handshake.
- On a start pulse it computes a signed or unsigned 32x32 product into {hi, lo} over 32 iterations.
- It does not contain its own adder. It borrows the execute-stage ALU by driving the ALU operands; the execute stage muxes those onto the ALU and forces the ALU to add while busy.
- It returns a one-cycle done pulse with hi/lo held stable afterwards.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  multiply request; sampled only in IDLE
sgn  input  1  1 = signed (two's-complement) operands, 0 = unsigned; sampled with start
src_a  input  WIDTH  multiplier operand; sampled with start
src_b  input  WIDTH  multiplicand operand; sampled with start
alu_y  input  WIDTH  ALU sum of alu_a + alu_b, same cycle (combinational return)
alu_a  output  WIDTH  ALU operand A request
alu_b  output  WIDTH  ALU operand B request
busy  output  1  high in RUN and FIX
done  output  1  one-cycle completion pulse
hi  output  WIDTH  upper product word
lo  output  WIDTH  lower product word

Behaviour:
- Reset (async, any state including mid-run):
  - state = IDLE; all registers 0.
  - hi = lo = 0, busy = 0, done = 0, alu_a = alu_b = 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with start = 1: latch mcand = |src_b| and mplr = |src_a| when sgn = 1, else the raw operands.
  - Latch neg = sgn & (src_a[MSB] ^ src_b[MSB]).
  - acc_hi = 0, acc_lo = mplr, count = 0; next state RUN.
  - |x| of the most negative value is 2^(WIDTH-1) taken as unsigned; this is correct.
- RUN (one iteration per cycle):
  - alu_a = acc_hi; alu_b = acc_lo[0] ? mcand : 0.
  - carry = (alu_a[MSB] & alu_b[MSB]) | ((alu_a[MSB] | alu_b[MSB]) & ~alu_y[MSB]).
  - Edge update: acc_hi <= {carry, alu_y[WIDTH-1:1]}; acc_lo <= {alu_y[0], acc_lo[WIDTH-1:1]}; count <= count + 1.
  - When count == WIDTH-1 at the edge, next state is FIX. Exactly WIDTH iterations are performed.
- FIX:
  - If neg, {acc_hi, acc_lo} <= two's-complement negation of the 2*WIDTH value, computed internally with no ALU use.
  - Next state DONE.
- DONE: done = 1 for exactly one cycle; next state IDLE.
- Outputs:
  - hi = acc_hi and lo = acc_lo at all times.
  - Values are final from the DONE cycle and held until the next accepted start.
- Latency: start sampled at edge T gives done high between edges T+WIDTH+1 and T+WIDTH+2 (33 cycles for WIDTH = 32).
- busy is registered-state decoded and high from edge T through edge T+WIDTH+1.
- alu_a = alu_b = 0 in every state except RUN.
- start while busy or in DONE is ignored; operands are not re-sampled.
- start in the same cycle as done is ignored. The next start is accepted from IDLE only.
- sgn = 0 with operand MSBs set: treated as unsigned, neg = 0.
- Zero operand: all iterations still run; latency is fixed and data-independent.

Test Plan:
1. Unsigned 7 x 6, bench ALU model y = a + b → hi = 0x00000000, lo = 0x0000002A; done pulses exactly 33 cycles after start for one cycle; busy high 33 cycles.
2. Unsigned 0xFFFFFFFF x 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Exercises the carry reconstruction on every iteration.
3. Signed -3 x 5 (0xFFFFFFFD, 0x00000005, sgn = 1) → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. Signed 0x80000000 x 0x80000000 → hi = 0x40000000, lo = 0x00000000.
4. Start re-asserted with new operands at cycles 5, 20, and on the done cycle → ignored; result still matches the first operands; next start from IDLE produces the new result.
5. rst asserted asynchronously mid-RUN (cycle 12) → busy, done, hi, lo, alu_a, alu_b all 0 immediately. A subsequent unsigned 3 x 4 returns lo = 0x0000000C with normal 33-cycle latency.
6. Idle check: with no start for 100 cycles → alu_a = alu_b = 0, busy = 0, done = 0, and hi/lo hold the last product (0x0000000C).
